connect_fork_unit: RTL and testbench

- Registered 1-to-N packet fork for the dataflow fabric.
- A single upstream valid/ready stream is buffered in an input register stage, steered to exactly one of CONNECT_NUM downstream channels, and re-buffered in a per-channel output register stage.
- Sits between a packet producer and CONNECT_NUM consumers; it never duplicates or drops packets.

---
 rtl/connect_fork_unit_pkg.sv | 12 +
 rtl/connect_fork_unit_if.sv | 26 ++
 rtl/connect_fork_unit_echo_stage.sv | 36 +++
 rtl/connect_fork_unit.sv | 62 ++++++
 tb/tb_connect_fork_unit.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/connect_fork_unit_pkg.sv
// Shared constants and valid/ready helpers for the connect fork slice.
package connect_fork_unit_pkg;

    localparam int unsigned PACKET_WIDTH        = 192;
    localparam int unsigned DEFAULT_CONNECT_NUM = 3;

    // A transfer happens on a rising edge where both valid and ready are high.
    function automatic logic xfer(input logic valid, input logic ready);
        return valid & ready;
    endfunction

endpackage

// File: rtl/connect_fork_unit_if.sv
// Upstream stream plus CONNECT_NUM flattened downstream channels.
interface connect_fork_unit_if
    import connect_fork_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = PACKET_WIDTH,
    parameter int unsigned CONNECT_NUM = DEFAULT_CONNECT_NUM
);

    logic                              RECEIVE_VALID;
    logic                              RECEIVE_READY;
    logic [DATA_WIDTH-1:0]             RECEIVE_DATA;
    logic [CONNECT_NUM-1:0]            SEND_VALID;
    logic [CONNECT_NUM-1:0]            SEND_READY;
    logic [DATA_WIDTH*CONNECT_NUM-1:0] SEND_DATA;

    modport master (
        output RECEIVE_VALID, RECEIVE_DATA, SEND_READY,
        input  RECEIVE_READY, SEND_VALID, SEND_DATA
    );

    modport slave (
        input  RECEIVE_VALID, RECEIVE_DATA, SEND_READY,
        output RECEIVE_READY, SEND_VALID, SEND_DATA
    );

endinterface

// File: rtl/connect_fork_unit_echo_stage.sv
// One-entry register slice: accepts only when empty, so a stage passes one packet per two cycles.
module echo_stage
    import connect_fork_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = PACKET_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic                  full;
    logic [DATA_WIDTH-1:0] data_q;

    assign in_ready  = !full && rst_n;
    assign out_valid = full;
    assign out_data  = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full   <= 1'b0;
            data_q <= '0;
        end else if (xfer(in_valid, in_ready)) begin
            full   <= 1'b1;
            data_q <= in_data;
        end else if (xfer(out_valid, out_ready)) begin
            full   <= 1'b0;
        end
    end

endmodule

// File: rtl/connect_fork_unit.sv
// Registered 1-to-N fork: input slice, highest-ready-channel steering, per-channel output slices.
module connect_fork_unit
    import connect_fork_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = PACKET_WIDTH,
    parameter int unsigned CONNECT_NUM = DEFAULT_CONNECT_NUM
) (
    input logic                CLK,
    input logic                RST,
    connect_fork_unit_if.slave bus
);

    logic                              fork_valid;
    logic                              fork_ready;
    logic [DATA_WIDTH-1:0]             fork_data;
    logic [CONNECT_NUM-1:0]            ch_ready;
    logic [CONNECT_NUM-1:0]            ch_valid;
    logic [CONNECT_NUM-1:0]            target;
    logic [CONNECT_NUM-1:0]            send_valid;
    logic [DATA_WIDTH*CONNECT_NUM-1:0] send_data;

    echo_stage #(.DATA_WIDTH(DATA_WIDTH)) u_input (
        .clk       (CLK),
        .rst_n     (RST),
        .in_valid  (bus.RECEIVE_VALID),
        .in_ready  (bus.RECEIVE_READY),
        .in_data   (bus.RECEIVE_DATA),
        .out_valid (fork_valid),
        .out_ready (fork_ready),
        .out_data  (fork_data)
    );

    // Ascending scan so the highest-index ready channel wins.
    always_comb begin
        target = '0;
        for (int unsigned i = 0; i < CONNECT_NUM; i++) begin
            if (ch_ready[i]) begin
                target    = '0;
                target[i] = 1'b1;
            end
        end
        ch_valid   = fork_valid ? target : '0;
        fork_ready = |ch_ready;
    end

    for (genvar g = 0; g < CONNECT_NUM; g++) begin : g_channel
        echo_stage #(.DATA_WIDTH(DATA_WIDTH)) u_channel (
            .clk       (CLK),
            .rst_n     (RST),
            .in_valid  (ch_valid[g]),
            .in_ready  (ch_ready[g]),
            .in_data   (fork_data),
            .out_valid (send_valid[g]),
            .out_ready (bus.SEND_READY[g]),
            .out_data  (send_data[DATA_WIDTH*(g+1)-1 -: DATA_WIDTH])
        );
    end

    assign bus.SEND_VALID = send_valid;
    assign bus.SEND_DATA  = send_data;

endmodule

// File: tb/tb_connect_fork_unit.sv
// Self-checking bench for connect_fork_unit: packet-slot model, scoreboard, directed and random traffic.
module tb_connect_fork_unit;
    import connect_fork_unit_pkg::*;

    localparam int unsigned DW = PACKET_WIDTH;
    localparam int unsigned CN = 3;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    connect_fork_unit_if #(.DATA_WIDTH(DW), .CONNECT_NUM(CN)) bus ();

    connect_fork_unit #(.DATA_WIDTH(DW), .CONNECT_NUM(CN)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int n_rcv    = 0;
    bit checking = 0;
    bit prod_done = 0;

    // Model: one slot for the input stage, one slot per channel.
    bit            m_in_full = 0;
    logic [DW-1:0] m_in_data = '0;
    bit            m_ch_full [CN];
    logic [DW-1:0] m_ch_data [CN];
    logic [DW-1:0] sb_q [$];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_pkt();
        logic [DW-1:0] p;
        for (int k = 0; k < DW / 32; k++) p[k*32 +: 32] = $urandom;
        return p;
    endfunction

    function automatic logic [DW-1:0] slice(input int ch);
        return bus.SEND_DATA[DW*ch +: DW];
    endfunction

    always @(posedge CLK or negedge RST) begin : model
        int            tgt;
        int            idx;
        bit            in_was_empty;
        logic [DW-1:0] v;
        if (!RST) begin
            m_in_full = 0;
            for (int i = 0; i < CN; i++) m_ch_full[i] = 0;
            sb_q.delete();
        end else begin
            if (bus.RECEIVE_VALID && bus.RECEIVE_READY) sb_q.push_back(bus.RECEIVE_DATA);
            for (int i = 0; i < CN; i++) begin
                if (bus.SEND_VALID[i] && bus.SEND_READY[i]) begin
                    v   = slice(i);
                    idx = -1;
                    foreach (sb_q[k]) if (idx < 0 && sb_q[k] == v) idx = k;
                    n_assert++;
                    if (idx < 0) begin
                        n_fail++;
                        $display("FAIL sb_ch%0d: got %h required a packet accepted earlier", i, v);
                    end else begin
                        sb_q.delete(idx);
                    end
                    n_rcv++;
                end
            end
            tgt = -1;
            for (int i = 0; i < CN; i++) if (!m_ch_full[i]) tgt = i;
            in_was_empty = !m_in_full;
            for (int i = 0; i < CN; i++) if (m_ch_full[i] && bus.SEND_READY[i]) m_ch_full[i] = 0;
            if (m_in_full && tgt >= 0) begin
                m_ch_full[tgt] = 1;
                m_ch_data[tgt] = m_in_data;
                m_in_full      = 0;
            end
            if (in_was_empty && bus.RECEIVE_VALID) begin
                m_in_full = 1;
                m_in_data = bus.RECEIVE_DATA;
            end
        end
    end

    always @(negedge CLK) begin : compare
        logic [CN-1:0] exp_valid;
        if (checking) begin
            for (int i = 0; i < CN; i++) exp_valid[i] = m_ch_full[i];
            chk("recv_ready", DW'(bus.RECEIVE_READY), DW'(!m_in_full && RST));
            chk("send_valid", DW'(bus.SEND_VALID), DW'(exp_valid));
            for (int i = 0; i < CN; i++)
                if (m_ch_full[i]) chk($sformatf("send_data_ch%0d", i), slice(i), m_ch_data[i]);
        end
    end

    task automatic send(input logic [DW-1:0] d);
        int n;
        bus.RECEIVE_VALID = 1'b1;
        bus.RECEIVE_DATA  = d;
        n = 0;
        while (!bus.RECEIVE_READY && n < 50) begin
            @(negedge CLK);
            n++;
        end
        n_assert++;
        if (!bus.RECEIVE_READY) begin
            n_fail++;
            $display("FAIL send_timeout: ready %0b, required 1 within 50 cycles", bus.RECEIVE_READY);
            bus.RECEIVE_VALID = 1'b0;
        end else begin
            @(negedge CLK);
            bus.RECEIVE_VALID = 1'b0;
        end
    endtask

    task automatic drain(input int ch);
        bus.SEND_READY[ch] = 1'b1;
        @(negedge CLK);
        bus.SEND_READY[ch] = 1'b0;
    endtask

    task automatic drain_all();
        bus.SEND_READY = '1;
        repeat (10) @(negedge CLK);
        bus.SEND_READY = '0;
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [DW-1:0] a, b, c, d, e, x;
        logic [DW-1:0] p [5];
        logic [CN-1:0] stale;
        int n;

        bus.RECEIVE_VALID = 1'b0;
        bus.RECEIVE_DATA  = '0;
        bus.SEND_READY    = '0;
        for (int i = 0; i < CN; i++) begin
            m_ch_full[i] = 0;
            m_ch_data[i] = '0;
        end
        #1 RST = 1'b0;
        checking = 1;

        // Reset
        @(negedge CLK);
        chk("reset_send_valid", DW'(bus.SEND_VALID), DW'(3'b000));
        chk("reset_recv_ready", DW'(bus.RECEIVE_READY), DW'(1'b0));
        #2 RST = 1'b1;
        @(negedge CLK);
        chk("post_reset_ready", DW'(bus.RECEIVE_READY), DW'(1'b1));

        // Sequential fill with no downstream ready
        a = rnd_pkt(); b = rnd_pkt(); c = rnd_pkt();
        send(a); send(b); send(c);
        repeat (2) @(negedge CLK);
        chk("fill_valid", DW'(bus.SEND_VALID), DW'(3'b111));
        chk("fill_ch2", slice(2), a);
        chk("fill_ch1", slice(1), b);
        chk("fill_ch0", slice(0), c);
        drain(2);
        chk("drain2_valid", DW'(bus.SEND_VALID), DW'(3'b011));
        drain(1);
        chk("drain1_valid", DW'(bus.SEND_VALID), DW'(3'b001));
        drain(0);
        chk("drain0_valid", DW'(bus.SEND_VALID), DW'(3'b000));

        // Backpressure: three channels plus input stage full
        for (int i = 0; i < 5; i++) p[i] = rnd_pkt();
        for (int i = 0; i < 4; i++) send(p[i]);
        chk("bp_ready_low", DW'(bus.RECEIVE_READY), DW'(1'b0));
        bus.RECEIVE_VALID = 1'b1;
        bus.RECEIVE_DATA  = p[4];
        repeat (3) @(negedge CLK);
        chk("bp_stall", DW'(bus.RECEIVE_READY), DW'(1'b0));
        chk("bp_ch1_before", slice(1), p[1]);
        drain(1);
        n = 0;
        while (!bus.SEND_VALID[1] && n < 2) begin
            @(negedge CLK);
            n++;
        end
        chk("bp_ch1_valid", DW'(bus.SEND_VALID[1]), DW'(1'b1));
        chk("bp_ch1_data", slice(1), p[3]);
        n = 0;
        while (!bus.RECEIVE_READY && n < 10) begin
            @(negedge CLK);
            n++;
        end
        chk("bp_ready_back", DW'(bus.RECEIVE_READY), DW'(1'b1));
        @(negedge CLK);
        bus.RECEIVE_VALID = 1'b0;
        drain_all();

        // Priority: ch2 busy sends D to ch1; freeing ch2 sends E to ch2
        x = rnd_pkt(); d = rnd_pkt(); e = rnd_pkt();
        send(x);
        repeat (2) @(negedge CLK);
        send(d);
        repeat (2) @(negedge CLK);
        chk("prio_valid", DW'(bus.SEND_VALID), DW'(3'b110));
        chk("prio_ch1_d", slice(1), d);
        drain(2);
        send(e);
        repeat (2) @(negedge CLK);
        chk("prio_valid_e", DW'(bus.SEND_VALID), DW'(3'b110));
        chk("prio_ch2_e", slice(2), e);
        drain_all();

        // Stress: concurrent producer and random consumer
        n_rcv = 0;
        fork
            begin
                for (int it = 0; it < 100; it++) begin
                    for (int g = 0; g < 3; g++) begin
                        for (int k = 0; k < (g == 2 ? 2 : 3); k++) send(rnd_pkt());
                        repeat ($urandom_range(0, 3)) @(negedge CLK);
                    end
                end
                prod_done = 1;
            end
            begin
                while (!prod_done) begin
                    @(negedge CLK);
                    bus.SEND_READY = CN'($urandom_range(0, (1 << CN) - 1));
                end
            end
        join
        drain_all();
        chk("stress_count", DW'(n_rcv), DW'(800));
        chk("stress_sb_empty", DW'(sb_q.size()), DW'(0));

        // Reset mid-operation with packets on ch0 and ch2
        send(rnd_pkt()); send(rnd_pkt()); send(rnd_pkt());
        repeat (2) @(negedge CLK);
        drain(1);
        @(negedge CLK);
        chk("mid_valid_before", DW'(bus.SEND_VALID), DW'(3'b101));
        #2 RST = 1'b0;
        #1;
        chk("mid_async_valid", DW'(bus.SEND_VALID), DW'(3'b000));
        chk("mid_async_ready", DW'(bus.RECEIVE_READY), DW'(1'b0));
        repeat (2) @(negedge CLK);
        #2 RST = 1'b1;
        bus.SEND_READY = '1;
        stale = '0;
        repeat (5) begin
            @(negedge CLK);
            stale |= bus.SEND_VALID;
        end
        chk("mid_no_stale", DW'(stale), DW'(3'b000));
        bus.SEND_READY = '0;

        checking = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
